// File: rtl/nbody_pair_sched.sv
// Pair scheduler for the accel phase: walks every (i,j) body pair into the accel pipeline and
// replays each pair PIPE_LAT cycles later as write-back tags.
module nbody_pair_sched #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int PIPE_LAT        = 123
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_hold,
  input  logic [BODY_ADDR_WIDTH:0]   i_num_bodies,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_issue_valid,
  output logic [BODY_ADDR_WIDTH-1:0] o_issue_i,
  output logic [BODY_ADDR_WIDTH-1:0] o_issue_j,
  output logic                       o_issue_self,
  output logic                       o_wb_valid,
  output logic [BODY_ADDR_WIDTH-1:0] o_wb_i,
  output logic [BODY_ADDR_WIDTH-1:0] o_wb_j,
  output logic                       o_wb_self,
  output logic                       o_wb_last_j
);

  localparam int AW = BODY_ADDR_WIDTH;
  localparam int OW = $clog2(PIPE_LAT + 1) + 1;
  localparam int DW = 2 * AW + 3;
  localparam logic [AW:0] N_MAX = (AW + 1)'(BODIES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    r_state, w_state_d;
  logic [AW-1:0] r_i, r_j, r_last;
  logic          r_busy, r_done;
  logic          r_issue_valid, r_issue_self, r_issue_last;
  logic [AW-1:0] r_issue_i, r_issue_j;
  logic [OW-1:0] r_out, w_out_d;
  logic [DW-1:0] r_dl [PIPE_LAT];

  logic [AW:0]   w_n;
  logic [AW-1:0] w_n_last, w_cur_i, w_cur_j, w_cur_last;
  logic          w_accept, w_multi, w_in_issue, w_emit, w_j_end, w_i_end, w_wb_valid;

  assign w_n        = (i_num_bodies > N_MAX) ? N_MAX : i_num_bodies;
  assign w_n_last   = AW'(w_n - (AW + 1)'(1));
  assign w_multi    = w_n > (AW + 1)'(1);
  assign w_accept   = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_in_issue = (r_state == ST_ISSUE);
  // The pair (0,0) goes out on the same edge that accepts start.
  assign w_emit     = !i_abort && !i_hold && (w_in_issue || (w_accept && w_multi));
  assign w_cur_i    = w_in_issue ? r_i : '0;
  assign w_cur_j    = w_in_issue ? r_j : '0;
  assign w_cur_last = w_in_issue ? r_last : w_n_last;
  assign w_j_end    = (w_cur_j == w_cur_last);
  assign w_i_end    = (w_cur_i == w_cur_last);
  assign w_wb_valid = r_dl[PIPE_LAT-1][DW-1];

  always_comb begin
    w_out_d = r_out;
    case ({r_issue_valid, w_wb_valid})
      2'b10:   w_out_d = r_out + OW'(1);
      2'b01:   w_out_d = r_out - OW'(1);
      default: w_out_d = r_out;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && w_multi) w_state_d = ST_ISSUE;
      ST_ISSUE: if (w_emit && w_i_end && w_j_end) w_state_d = ST_DRAIN;
      ST_DRAIN: if (w_out_d == '0) w_state_d = ST_DONE;
      default:  w_state_d = ST_IDLE;
    endcase
    if (i_abort) w_state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_last        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_issue_valid <= 1'b0;
      r_issue_self  <= 1'b0;
      r_issue_last  <= 1'b0;
      r_issue_i     <= '0;
      r_issue_j     <= '0;
      r_out         <= '0;
    end else begin
      r_state       <= w_state_d;
      r_busy        <= (w_state_d == ST_ISSUE) || (w_state_d == ST_DRAIN);
      r_done        <= (w_accept && !w_multi) || ((r_state == ST_DRAIN) && (w_state_d == ST_DONE));
      r_issue_valid <= w_emit;
      r_issue_self  <= w_emit && (w_cur_i == w_cur_j);
      r_issue_last  <= w_emit && w_j_end;
      r_out         <= i_abort ? '0 : w_out_d;
      if (w_accept) r_last <= w_n_last;
      if (w_emit) begin
        r_issue_i <= w_cur_i;
        r_issue_j <= w_cur_j;
        if (!w_j_end) begin
          r_i <= w_cur_i;
          r_j <= w_cur_j + AW'(1);
        end else begin
          r_j <= '0;
          // Hold i on the final pair so a full-size pass never wraps the counter.
          r_i <= w_i_end ? w_cur_i : w_cur_i + AW'(1);
        end
      end else if (w_accept) begin
        r_i <= '0;
        r_j <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) r_dl[k] <= '0;
    end else if (i_abort) begin
      for (int k = 0; k < PIPE_LAT; k++) r_dl[k] <= '0;
    end else begin
      r_dl[0] <= {r_issue_valid, r_issue_i, r_issue_j, r_issue_self, r_issue_last};
      for (int k = 1; k < PIPE_LAT; k++) r_dl[k] <= r_dl[k-1];
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_issue_valid = r_issue_valid;
  assign o_issue_i     = r_issue_i;
  assign o_issue_j     = r_issue_j;
  assign o_issue_self  = r_issue_self;
  assign o_wb_valid    = w_wb_valid;
  assign o_wb_i        = r_dl[PIPE_LAT-1][DW-2 -: AW];
  assign o_wb_j        = r_dl[PIPE_LAT-1][AW+1 -: AW];
  assign o_wb_self     = r_dl[PIPE_LAT-1][1];
  assign o_wb_last_j   = r_dl[PIPE_LAT-1][0];

endmodule

// File: tb/tb_nbody_pair_sched.sv
// Directed bench for nbody_pair_sched, built with a 16-body limit so full passes stay short.
module tb_nbody_pair_sched;

  localparam int BODIES = 16;
  localparam int AW     = 4;
  localparam int LAT    = 123;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_abort, i_hold;
  logic [AW:0]   i_num_bodies;
  logic          o_busy, o_done, o_issue_valid, o_issue_self;
  logic [AW-1:0] o_issue_i, o_issue_j, o_wb_i, o_wb_j;
  logic          o_wb_valid, o_wb_self, o_wb_last_j;

  always #5 clk = ~clk;

  nbody_pair_sched #(
    .BODIES          (BODIES),
    .BODY_ADDR_WIDTH (AW),
    .PIPE_LAT        (LAT)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_hold        (i_hold),
    .i_num_bodies  (i_num_bodies),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_issue_valid (o_issue_valid),
    .o_issue_i     (o_issue_i),
    .o_issue_j     (o_issue_j),
    .o_issue_self  (o_issue_self),
    .o_wb_valid    (o_wb_valid),
    .o_wb_i        (o_wb_i),
    .o_wb_j        (o_wb_j),
    .o_wb_self     (o_wb_self),
    .o_wb_last_j   (o_wb_last_j)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Pair order for a 3-body pass, {i,j} nibbles.
  logic [7:0] n3_pairs [9] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};

  int         res_iss, res_wb, res_done, res_done_cyc, res_busy, res_last_j;
  int         res_wb_late, res_busy_ab;
  logic [7:0] res_last_iss, res_last_wb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 3-body pass with hold asserted so that cycles h0..h1 carry no issue.
  task automatic run_n3(input string tag, input int h0, input int h1);
    logic v_tr [0:299];
    int   k_tr [0:299];
    int   k, nhold, last_c, kk;
    logic exp_v, exp_wv;
    nhold  = (h1 >= h0) ? (h1 - h0 + 1) : 0;
    last_c = 9 + nhold;
    k      = 0;
    i_num_bodies = 5'd3;
    i_hold  = (1 >= h0) && (1 <= h1);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 1; c <= last_c + LAT + 3; c++) begin
      exp_v = (c <= last_c) && !((c >= h0) && (c <= h1));
      check($sformatf("%s issue_valid@%0d", tag, c), 32'(o_issue_valid), 32'(exp_v));
      if (exp_v) begin
        check($sformatf("%s issue_ij@%0d", tag, c), 32'({o_issue_i, o_issue_j}),
              32'(n3_pairs[k]));
        check($sformatf("%s issue_self@%0d", tag, c), 32'(o_issue_self), 32'(k % 4 == 0));
      end
      v_tr[c] = exp_v;
      k_tr[c] = k;
      if (exp_v) k++;
      exp_wv = (c - LAT >= 1) ? v_tr[c-LAT] : 1'b0;
      check($sformatf("%s wb_valid@%0d", tag, c), 32'(o_wb_valid), 32'(exp_wv));
      if (exp_wv) begin
        kk = k_tr[c-LAT];
        check($sformatf("%s wb_ij@%0d", tag, c), 32'({o_wb_i, o_wb_j}), 32'(n3_pairs[kk]));
        check($sformatf("%s wb_self@%0d", tag, c), 32'(o_wb_self), 32'(kk % 4 == 0));
        check($sformatf("%s wb_last_j@%0d", tag, c), 32'(o_wb_last_j), 32'(kk % 3 == 2));
      end
      check($sformatf("%s done@%0d", tag, c), 32'(o_done), 32'(c == last_c + LAT + 1));
      check($sformatf("%s busy@%0d", tag, c), 32'(o_busy), 32'(c <= last_c + LAT));
      i_hold = ((c + 1) >= h0) && ((c + 1) <= h1);
      step();
    end
    i_hold = 1'b0;
  endtask

  // Generic pass: optional start re-pulse (nb 2 then 7) and optional abort, summarised in res_*.
  task automatic run_pass(input logic [AW:0] nb, input int restart_at, input int abort_at,
                          input int max_cyc);
    int stop_c;
    res_iss = 0; res_wb = 0; res_done = 0; res_done_cyc = 0; res_busy = 0; res_last_j = 0;
    res_wb_late = 0; res_busy_ab = -1; res_last_iss = '0; res_last_wb = '0;
    i_num_bodies = nb;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    stop_c = max_cyc;
    for (int c = 1; c <= stop_c; c++) begin
      if (o_issue_valid) begin
        res_iss++;
        res_last_iss = {o_issue_i, o_issue_j};
      end
      if (o_wb_valid) begin
        res_wb++;
        res_last_wb = {o_wb_i, o_wb_j};
        if (o_wb_last_j) res_last_j++;
        if (abort_at > 0 && c > abort_at) res_wb_late++;
      end
      if (o_busy) res_busy++;
      if (o_done) begin
        res_done++;
        if (res_done_cyc == 0) res_done_cyc = c;
        if (stop_c > c + 5) stop_c = c + 5;
      end
      if (abort_at > 0 && c == abort_at + 1) begin
        res_busy_ab = int'(o_busy);
        stop_c = c + LAT + 10;
      end
      i_start = (restart_at > 0) && (c == restart_at || c == restart_at + 1);
      if (restart_at > 0 && c == restart_at) i_num_bodies = 5'd2;
      if (restart_at > 0 && c == restart_at + 1) i_num_bodies = 5'd7;
      i_abort = (abort_at > 0) && (c == abort_at);
      step();
    end
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  initial begin
    int cnt_wb, cnt_busy, cnt_done;
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_hold = 1'b0; i_num_bodies = '0;
    step();
    step();
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset done", 32'(o_done), 32'd0);
    check("reset issue_valid", 32'(o_issue_valid), 32'd0);
    check("reset wb_valid", 32'(o_wb_valid), 32'd0);
    check("reset indices", 32'({o_issue_i, o_issue_j, o_wb_i, o_wb_j}), 32'd0);
    rst = 1'b0;
    step();

    run_n3("n3", 0, -1);
    run_n3("n3hold", 4, 5);

    run_pass(5'd0, 0, 0, 20);
    check("n0 done count", res_done, 1);
    check("n0 done cycle", res_done_cyc, 1);
    check("n0 issues", res_iss, 0);
    check("n0 busy cycles", res_busy, 0);
    run_pass(5'd1, 0, 0, 20);
    check("n1 done count", res_done, 1);
    check("n1 done cycle", res_done_cyc, 1);
    check("n1 issues", res_iss, 0);
    check("n1 wb", res_wb, 0);
    check("n1 busy cycles", res_busy, 0);

    run_pass(5'd16, 0, 50, 1000);
    check("abort issues", res_iss, 50);
    check("abort busy@51", res_busy_ab, 0);
    check("abort late wb", res_wb_late, 0);
    check("abort done", res_done, 0);
    run_pass(5'd16, 0, 0, 1000);
    check("n16 issues", res_iss, 256);
    check("n16 wb", res_wb, 256);
    check("n16 done count", res_done, 1);
    check("n16 done cycle", res_done_cyc, 256 + LAT + 1);
    check("n16 busy cycles", res_busy, 256 + LAT);
    check("n16 last wb", 32'(res_last_wb), 32'h ff);
    check("n16 wb_last_j count", res_last_j, 16);

    run_pass(5'd4, 5, 0, 1000);
    check("restart issues", res_iss, 16);
    check("restart wb", res_wb, 16);
    check("restart done count", res_done, 1);
    check("restart done cycle", res_done_cyc, 16 + LAT + 1);
    check("restart last issue", 32'(res_last_iss), 32'h33);
    check("restart last wb", 32'(res_last_wb), 32'h33);

    i_num_bodies = 5'd4; i_start = 1'b1; i_abort = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    check("start+abort busy", 32'(o_busy), 32'd0);
    check("start+abort issue", 32'(o_issue_valid), 32'd0);
    step();
    check("start+abort busy later", 32'(o_busy), 32'd0);

    run_pass(5'd20, 0, 0, 1000);
    check("clamp issues", res_iss, 256);
    check("clamp last issue", 32'(res_last_iss), 32'h ff);
    check("clamp done count", res_done, 1);
    check("clamp done cycle", res_done_cyc, 256 + LAT + 1);

    i_num_bodies = 5'd16; i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (150) step();
    check("pre-rst busy", 32'(o_busy), 32'd1);
    check("pre-rst wb_valid", 32'(o_wb_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst flags", 32'({o_busy, o_done, o_issue_valid, o_issue_self, o_wb_valid,
                                  o_wb_self, o_wb_last_j}), 32'd0);
    check("async rst indices", 32'({o_issue_i, o_issue_j, o_wb_i, o_wb_j}), 32'd0);
    #1 rst = 1'b0;
    cnt_wb = 0; cnt_busy = 0; cnt_done = 0;
    repeat (LAT + 5) begin
      step();
      if (o_wb_valid) cnt_wb++;
      if (o_busy) cnt_busy++;
      if (o_done) cnt_done++;
    end
    check("post-rst wb", cnt_wb, 0);
    check("post-rst busy", cnt_busy, 0);
    check("post-rst done", cnt_done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
